ddr_to_icb_reader: RTL and testbench

- ICB read-responder that gives the RISC-V core (ICB slave port s8) word access to a DDR window through the DDR controller's AXI read channel.
- Read path counterpart of the ICB-to-DDR write bridge.
- Each 32-bit ICB read fetches one 256-bit DDR beat (arlen=0) and returns the addressed word.
- The last fetched 32-byte line is held in a one-line buffer so sequential word reads hit without a DDR access.

---
 rtl/ddr_to_icb_reader.sv | 175 +++++++++++++++++
 tb/tb_ddr_to_icb_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_to_icb_reader.sv
// ICB read responder: serves 32-bit word reads from a DDR window via single-beat AXI reads,
// keeping the last fetched 256-bit line so sequential reads within a line hit locally.
module ddr_to_icb_reader #(
  parameter int unsigned OFS_W   = 24,
  parameter logic [31:0] MODE_RD = 32'h0000_0020
) (
  input  logic         ddr_clk,
  input  logic         ddr_rst_n,
  input  logic         s8_icb_cmd_valid,
  output logic         s8_icb_cmd_ready,
  input  logic [31:0]  s8_icb_cmd_addr,
  input  logic         s8_icb_cmd_read,
  input  logic [31:0]  s8_icb_cmd_wdata,
  input  logic [3:0]   s8_icb_cmd_wmask,
  output logic         s8_icb_rsp_valid,
  input  logic         s8_icb_rsp_ready,
  output logic [31:0]  s8_icb_rsp_rdata,
  output logic         s8_icb_rsp_err,
  input  logic [31:0]  slave_lite_reg5,
  input  logic [31:0]  slave_lite_reg7,
  input  logic [31:0]  slave_lite_reg8,
  output logic [27:0]  ddr_axi_araddr,
  output logic [3:0]   ddr_axi_aruser_id,
  output logic [3:0]   ddr_axi_arlen,
  output logic         ddr_axi_arvalid,
  input  logic         ddr_axi_arready,
  input  logic [255:0] ddr_axi_rdata,
  input  logic [3:0]   ddr_axi_rid,
  input  logic         ddr_axi_rlast,
  input  logic         ddr_axi_rvalid
);

  typedef enum logic [1:0] {IDLE, AR, R, RSP} state_e;

  state_e         state_q, state_d;
  logic           line_valid_q, line_valid_d;
  logic [27:0]    line_tag_q, line_tag_d;
  logic [255:0]   line_q, line_d;
  logic [2:0]     wsel_q, wsel_d;
  logic           stale_q, stale_d;
  logic [31:0]    reg7_q;
  logic           arvalid_q, arvalid_d;
  logic [27:0]    araddr_q, araddr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;

  logic [OFS_W-1:0] ofs;
  logic [27:0]      line_addr;
  logic [2:0]       wsel;
  logic             mode_ok, inv, hit, accept, beat_ok;
  logic             unused_ok;

  assign unused_ok = ^{s8_icb_cmd_wdata, s8_icb_cmd_wmask,
                       s8_icb_cmd_addr[31:OFS_W], s8_icb_cmd_addr[1:0]};

  assign ofs       = s8_icb_cmd_addr[OFS_W-1:0];
  assign line_addr = slave_lite_reg7[27:0] + 28'({ofs[OFS_W-1:5], 5'b0});
  assign wsel      = ofs[4:2];
  assign mode_ok   = (slave_lite_reg5 == MODE_RD);
  assign inv       = !mode_ok || (slave_lite_reg7 != reg7_q);
  assign hit       = line_valid_q && !inv && (line_tag_q == line_addr);
  assign beat_ok   = ddr_axi_rvalid && (ddr_axi_rid == 4'h1);

  assign s8_icb_cmd_ready  = (state_q == IDLE) && ddr_rst_n;
  assign accept            = s8_icb_cmd_valid && s8_icb_cmd_ready;
  assign s8_icb_rsp_valid  = rsp_valid_q;
  assign s8_icb_rsp_rdata  = rsp_rdata_q;
  assign s8_icb_rsp_err    = rsp_err_q;
  assign ddr_axi_araddr    = araddr_q;
  assign ddr_axi_arvalid   = arvalid_q;
  assign ddr_axi_aruser_id = 4'h1;
  assign ddr_axi_arlen     = 4'h0;

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    line_tag_d   = line_tag_q;
    line_d       = line_q;
    wsel_d       = wsel_q;
    stale_d      = stale_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    if (inv) line_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!s8_icb_cmd_read || !mode_ok || (32'(ofs) >= slave_lite_reg8)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RSP;
          end else if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = line_q[{wsel, 5'b0} +: 32];
            state_d     = RSP;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = line_addr;
            wsel_d    = wsel;
            stale_d   = 1'b0;
            state_d   = AR;
          end
        end
      end
      AR: begin
        if (inv) stale_d = 1'b1;
        if (ddr_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = R;
        end
      end
      R: begin
        if (inv) stale_d = 1'b1;
        if (beat_ok) begin
          line_d       = ddr_axi_rdata;
          line_tag_d   = araddr_q;
          line_valid_d = 1'b0;
          if (ddr_axi_rlast) begin
            // an invalidation seen anywhere during the fetch keeps the line unusable
            line_valid_d = !(inv || stale_q);
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b0;
            rsp_rdata_d  = ddr_axi_rdata[{wsel_q, 5'b0} +: 32];
            state_d      = RSP;
          end
        end
      end
      RSP: begin
        if (s8_icb_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state_q      <= IDLE;
      line_valid_q <= 1'b0;
      line_tag_q   <= '0;
      line_q       <= '0;
      wsel_q       <= '0;
      stale_q      <= 1'b0;
      reg7_q       <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      line_tag_q   <= line_tag_d;
      line_q       <= line_d;
      wsel_q       <= wsel_d;
      stale_q      <= stale_d;
      reg7_q       <= slave_lite_reg7;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ddr_to_icb_reader.sv
// Directed bench for ddr_to_icb_reader: table of single-read transactions plus
// hand-written sequences for stalls, stray beats, base changes, wrap and mid-fetch reset.
module tb_ddr_to_icb_reader;

  logic         ddr_clk, ddr_rst_n;
  logic         s8_icb_cmd_valid, s8_icb_cmd_ready, s8_icb_cmd_read;
  logic [31:0]  s8_icb_cmd_addr, s8_icb_cmd_wdata;
  logic [3:0]   s8_icb_cmd_wmask;
  logic         s8_icb_rsp_valid, s8_icb_rsp_ready, s8_icb_rsp_err;
  logic [31:0]  s8_icb_rsp_rdata;
  logic [31:0]  slave_lite_reg5, slave_lite_reg7, slave_lite_reg8;
  logic [27:0]  ddr_axi_araddr;
  logic [3:0]   ddr_axi_aruser_id, ddr_axi_arlen, ddr_axi_rid;
  logic         ddr_axi_arvalid, ddr_axi_arready, ddr_axi_rlast, ddr_axi_rvalid;
  logic [255:0] ddr_axi_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  ddr_to_icb_reader #(.OFS_W(24), .MODE_RD(32'h0000_0020)) dut (
    .ddr_clk(ddr_clk), .ddr_rst_n(ddr_rst_n),
    .s8_icb_cmd_valid(s8_icb_cmd_valid), .s8_icb_cmd_ready(s8_icb_cmd_ready),
    .s8_icb_cmd_addr(s8_icb_cmd_addr), .s8_icb_cmd_read(s8_icb_cmd_read),
    .s8_icb_cmd_wdata(s8_icb_cmd_wdata), .s8_icb_cmd_wmask(s8_icb_cmd_wmask),
    .s8_icb_rsp_valid(s8_icb_rsp_valid), .s8_icb_rsp_ready(s8_icb_rsp_ready),
    .s8_icb_rsp_rdata(s8_icb_rsp_rdata), .s8_icb_rsp_err(s8_icb_rsp_err),
    .slave_lite_reg5(slave_lite_reg5), .slave_lite_reg7(slave_lite_reg7),
    .slave_lite_reg8(slave_lite_reg8),
    .ddr_axi_araddr(ddr_axi_araddr), .ddr_axi_aruser_id(ddr_axi_aruser_id),
    .ddr_axi_arlen(ddr_axi_arlen), .ddr_axi_arvalid(ddr_axi_arvalid),
    .ddr_axi_arready(ddr_axi_arready), .ddr_axi_rdata(ddr_axi_rdata),
    .ddr_axi_rid(ddr_axi_rid), .ddr_axi_rlast(ddr_axi_rlast),
    .ddr_axi_rvalid(ddr_axi_rvalid)
  );

  initial ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // DDR content model: word k of line L is {L[23:0], k} ^ 5A000000, except one planted word
  function automatic logic [255:0] make_beat(input logic [27:0] l);
    logic [255:0] b;
    for (int unsigned k = 0; k < 8; k++) begin
      if (l == 28'h100_0020 && k == 1) b[k*32 +: 32] = 32'hDEAD_BEEF;
      else b[k*32 +: 32] = {l[23:0], 8'(k)} ^ 32'h5A00_0000;
    end
    return b;
  endfunction

  task automatic do_txn(input logic rd, input logic [31:0] a_in, input int ar_dly,
                        input int rsp_dly, input logic bad_beat,
                        output logic got_ar, output logic [27:0] ar_a,
                        output logic [31:0] rdat, output logic err, output int lat);
    int n;
    got_ar = 1'b0; ar_a = '0; rdat = '0; err = 1'b0; lat = 0;
    n = 0;
    while (!s8_icb_cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", 64'(s8_icb_cmd_ready), 64'd1);
    s8_icb_cmd_valid = 1'b1; s8_icb_cmd_read = rd; s8_icb_cmd_addr = a_in;
    tick();
    s8_icb_cmd_valid = 1'b0;
    n = 0;
    while (!s8_icb_rsp_valid && n < 100) begin
      if (ddr_axi_arvalid) begin
        got_ar = 1'b1;
        ar_a   = ddr_axi_araddr;
        chk("arlen", 64'(ddr_axi_arlen), 64'h0);
        chk("aruser", 64'(ddr_axi_aruser_id), 64'h1);
        for (int i = 0; i < ar_dly; i++) begin
          tick();
          chk("ar_hold", 64'({ddr_axi_arvalid, ddr_axi_araddr}), 64'({1'b1, ar_a}));
        end
        ddr_axi_arready = 1'b1;
        tick();
        ddr_axi_arready = 1'b0;
        chk("ar_drop", 64'(ddr_axi_arvalid), 64'd0);
        if (bad_beat) begin
          ddr_axi_rvalid = 1'b1; ddr_axi_rid = 4'h2; ddr_axi_rlast = 1'b1;
          ddr_axi_rdata = '1;
          tick();
          chk("bad_id_ignored", 64'(s8_icb_rsp_valid), 64'd0);
        end
        ddr_axi_rvalid = 1'b1; ddr_axi_rid = 4'h1; ddr_axi_rlast = 1'b1;
        ddr_axi_rdata = make_beat(ar_a);
        tick();
        ddr_axi_rvalid = 1'b0; ddr_axi_rlast = 1'b0; ddr_axi_rdata = '0;
      end else begin
        tick();
        n++;
      end
    end
    lat = n;
    chk("rsp_valid_wait", 64'(s8_icb_rsp_valid), 64'd1);
    rdat = s8_icb_rsp_rdata;
    err  = s8_icb_rsp_err;
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      chk("rsp_hold", 64'({s8_icb_rsp_valid, s8_icb_rsp_err, s8_icb_rsp_rdata}),
          64'({1'b1, err, rdat}));
    end
    s8_icb_rsp_ready = 1'b1;
    tick();
    s8_icb_rsp_ready = 1'b0;
    chk("rsp_drop", 64'(s8_icb_rsp_valid), 64'd0);
  endtask

  task automatic run(input string nm, input logic rd, input logic [31:0] a_in,
                     input logic exp_ar, input logic [27:0] exp_araddr,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int ar_dly, input int rsp_dly, input logic bad_beat);
    logic got_ar, err;
    logic [27:0] ar_a;
    logic [31:0] rdat;
    int lat;
    do_txn(rd, a_in, ar_dly, rsp_dly, bad_beat, got_ar, ar_a, rdat, err, lat);
    chk({nm, "_ar"}, 64'(got_ar), 64'(exp_ar));
    if (exp_ar) chk({nm, "_araddr"}, 64'(ar_a), 64'(exp_araddr));
    chk({nm, "_rdata"}, 64'(rdat), 64'(exp_rdata));
    chk({nm, "_err"}, 64'(err), 64'(exp_err));
    chk({nm, "_latency"}, 64'(lat), 64'd0);
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] reg5, reg8, addr;
    logic        exp_ar;
    logic [27:0] exp_araddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1, 32'h20, 32'h1000, 32'h0000_0024, 1'b1, 28'h100_0020, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h20, 32'h1000, 32'h0000_0028, 1'b0, 28'h0,        32'h5A00_2002, 1'b0};
    vecs[2]  = '{1'b0, 32'h20, 32'h1000, 32'h0000_0028, 1'b0, 28'h0,        32'h0,         1'b1};
    vecs[3]  = '{1'b1, 32'h10, 32'h1000, 32'h0000_0028, 1'b0, 28'h0,        32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h20, 32'h40,   32'h0000_0040, 1'b0, 28'h0,        32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h20, 32'h40,   32'h0000_003C, 1'b1, 28'h100_0020, 32'h5A00_2007, 1'b0};
    vecs[6]  = '{1'b1, 32'h20, 32'h1000, 32'h0000_0030, 1'b0, 28'h0,        32'h5A00_2004, 1'b0};
    vecs[7]  = '{1'b1, 32'h20, 32'h1000, 32'h0000_0FE0, 1'b1, 28'h100_0FE0, 32'h5A0F_E000, 1'b0};
    vecs[8]  = '{1'b1, 32'h20, 32'h0,    32'h0000_0000, 1'b0, 28'h0,        32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h20, 32'h1000, 32'hFF00_0044, 1'b1, 28'h100_0040, 32'h5A00_4001, 1'b0};
    vecs[10] = '{1'b1, 32'h20, 32'h1000, 32'h0000_0047, 1'b0, 28'h0,        32'h5A00_4001, 1'b0};
    vecs[11] = '{1'b1, 32'h20, 32'h45,   32'h0000_0044, 1'b0, 28'h0,        32'h5A00_4001, 1'b0};
    vecs[12] = '{1'b1, 32'h20, 32'h45,   32'h0000_0045, 1'b0, 28'h0,        32'h0,         1'b1};

    ddr_rst_n = 1'b0;
    s8_icb_cmd_valid = 1'b0; s8_icb_cmd_read = 1'b1; s8_icb_cmd_addr = '0;
    s8_icb_cmd_wdata = 32'h1234_5678; s8_icb_cmd_wmask = 4'hF; s8_icb_rsp_ready = 1'b0;
    slave_lite_reg5 = 32'h20; slave_lite_reg7 = 32'h0100_0000; slave_lite_reg8 = 32'h1000;
    ddr_axi_arready = 1'b0; ddr_axi_rdata = '0; ddr_axi_rid = 4'h1;
    ddr_axi_rlast = 1'b0; ddr_axi_rvalid = 1'b0;

    repeat (3) tick();
    chk("rst_cmd_ready", 64'(s8_icb_cmd_ready), 64'd0);
    chk("rst_arvalid", 64'(ddr_axi_arvalid), 64'd0);
    chk("rst_araddr", 64'(ddr_axi_araddr), 64'd0);
    chk("rst_rsp", 64'({s8_icb_rsp_valid, s8_icb_rsp_err, s8_icb_rsp_rdata}), 64'd0);
    chk("const_ar", 64'({ddr_axi_arlen, ddr_axi_aruser_id}), 64'h01);
    ddr_rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_cmd_ready", 64'(s8_icb_cmd_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      slave_lite_reg5 = vecs[i].reg5;
      slave_lite_reg8 = vecs[i].reg8;
      tick();
      run($sformatf("v%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].exp_ar,
          vecs[i].exp_araddr, vecs[i].exp_rdata, vecs[i].exp_err, 0, 0, 1'b0);
    end

    // stalls on AR and RSP with a wrong-id beat, then a stray beat in IDLE
    slave_lite_reg8 = 32'h1000;
    tick();
    run("stall", 1'b1, 32'h104, 1'b1, 28'h100_0100, 32'h5A01_0001, 1'b0, 10, 5, 1'b1);
    ddr_axi_rvalid = 1'b1; ddr_axi_rid = 4'h1; ddr_axi_rlast = 1'b1; ddr_axi_rdata = '1;
    tick();
    ddr_axi_rvalid = 1'b0; ddr_axi_rlast = 1'b0; ddr_axi_rdata = '0;
    chk("stray_idle_rsp", 64'(s8_icb_rsp_valid), 64'd0);
    run("stray_hit", 1'b1, 32'h108, 1'b0, 28'h0, 32'h5A01_0002, 1'b0, 0, 0, 1'b0);

    // base change forces a refetch, then the new line hits
    slave_lite_reg7 = 32'h0200_0000;
    tick();
    run("rebase", 1'b1, 32'h108, 1'b1, 28'h200_0100, 32'h5A01_0002, 1'b0, 0, 0, 1'b0);
    run("rebase_hit", 1'b1, 32'h10C, 1'b0, 28'h0, 32'h5A01_0003, 1'b0, 0, 0, 1'b0);

    // line address wraps modulo 2^28
    slave_lite_reg7 = 32'h0FFF_FFE0;
    tick();
    run("wrap", 1'b1, 32'h24, 1'b1, 28'h000_0000, 32'h5A00_0001, 1'b0, 0, 0, 1'b0);

    // reset while the read address is outstanding
    slave_lite_reg7 = 32'h0300_0000;
    tick();
    s8_icb_cmd_valid = 1'b1; s8_icb_cmd_read = 1'b1; s8_icb_cmd_addr = 32'h200;
    tick();
    s8_icb_cmd_valid = 1'b0;
    chk("abort_arvalid_before", 64'({ddr_axi_arvalid, ddr_axi_araddr}), 64'({1'b1, 28'h300_0200}));
    #2 ddr_rst_n = 1'b0;
    #1;
    chk("abort_arvalid", 64'(ddr_axi_arvalid), 64'd0);
    chk("abort_cmd_ready", 64'(s8_icb_cmd_ready), 64'd0);
    tick();
    ddr_rst_n = 1'b1;
    ddr_axi_rvalid = 1'b1; ddr_axi_rid = 4'h1; ddr_axi_rlast = 1'b1; ddr_axi_rdata = '1;
    tick();
    ddr_axi_rvalid = 1'b0; ddr_axi_rlast = 1'b0; ddr_axi_rdata = '0;
    chk("abort_late_beat", 64'({s8_icb_rsp_valid, ddr_axi_arvalid, s8_icb_cmd_ready}), 64'b001);
    run("refetch", 1'b1, 32'h200, 1'b1, 28'h300_0200, 32'h5A02_0000, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
